// File: rtl/inv_sqrt_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : inv_sqrt_arbiter_if
// Brief    : Request/response/engine bundle of the shared 1/sqrt arbiter.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface inv_sqrt_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_x;
    logic [N_REQ-1:0]    rsp_valid;
    logic [N_REQ-1:0]    rsp_ready;
    logic [32*N_REQ-1:0] rsp_y;
    logic                eng_valid;
    logic [31:0]         eng_x;
    logic [31:0]         eng_y;
    logic                busy;

    modport slave (
        input  req_valid, req_x, rsp_ready, eng_y,
        output req_ready, rsp_valid, rsp_y, eng_valid, eng_x, busy
    );

    modport master (
        output req_valid, req_x, rsp_ready, eng_y,
        input  req_ready, rsp_valid, rsp_y, eng_valid, eng_x, busy
    );
endinterface
`default_nettype wire

// File: rtl/inv_sqrt_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : inv_sqrt_arbiter
// Brief    : Credit-gated round-robin sharing of one fixed-latency Q16.16
//            1/sqrt engine, with per-requester response FIFOs.
//            Optional INV_SQRT_ARB_PERF_EN adds issue/stall counters.
// Revision : 1.0
// ---------------------------------------------------------------------------
module inv_sqrt_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ENG_LAT   = 6,
    parameter int RSP_DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    inv_sqrt_arbiter_if.slave   io_bus
`ifdef INV_SQRT_ARB_PERF_EN
    ,
    output logic [31:0]         o_perf_issue,
    output logic [31:0]         o_perf_stall
`endif
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int AW  = $clog2(RSP_DEPTH);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam logic [IDW:0]   c_NREQ  = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] c_LAST  = IDW'(N_REQ - 1);
    localparam logic [CW-1:0]  c_DEPTH = CW'(RSP_DEPTH);

    logic [IDW-1:0]   r_rr;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_gnt_vec;
    logic [N_REQ-1:0] w_pop;
    logic [N_REQ-1:0] w_wr;
    logic [N_REQ-1:0] w_nempty;
    logic             w_gnt_any;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW:0]     w_idx;
    logic [IDW-1:0]   w_rr_nxt;
    logic [31:0]      w_x [N_REQ];

    logic             r_eng_valid;
    logic [31:0]      r_eng_x;
    logic [IDW-1:0]   r_iss_id;
    logic [ENG_LAT-1:0] r_tag_v;
    logic [IDW-1:0]   r_tag_id [ENG_LAT];
    logic             w_tag_v;
    logic [IDW-1:0]   w_tag_id;

    // Rotating priority search starting at r_rr, first eligible wins
    always_comb begin
        w_gnt_vec = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_rr} + (IDW+1)'(k);
            if (w_idx >= c_NREQ) begin
                w_idx = w_idx - c_NREQ;
            end
            if (!w_gnt_any && w_elig[w_idx[IDW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_idx[IDW-1:0];
            end
        end
        if (w_gnt_any) begin
            w_gnt_vec[w_gnt_id] = 1'b1;
        end
    end

    assign w_rr_nxt = (w_gnt_id == c_LAST) ? '0 : w_gnt_id + 1'b1;

    // The issue register carries the tag alongside the operand so the
    // ENG_LAT-deep shift below lines up exactly with the engine's output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eng_valid <= 1'b0;
            r_eng_x     <= '0;
            r_iss_id    <= '0;
            r_rr        <= '0;
            r_tag_v     <= '0;
            for (int k = 0; k < ENG_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_eng_valid <= w_gnt_any;
            r_eng_x     <= w_gnt_any ? w_x[w_gnt_id] : 32'd0;
            r_iss_id    <= w_gnt_id;
            if (w_gnt_any) begin
                r_rr <= w_rr_nxt;
            end
            r_tag_v[0]  <= r_eng_valid;
            r_tag_id[0] <= r_iss_id;
            for (int k = 1; k < ENG_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    assign w_tag_v  = r_tag_v[ENG_LAT-1];
    assign w_tag_id = r_tag_id[ENG_LAT-1];

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_req
            logic [CW-1:0] r_cnt;
            logic [AW:0]   r_wp;
            logic [AW:0]   r_rp;
            logic [31:0]   r_mem [RSP_DEPTH];

            assign w_x[i]      = io_bus.req_x[32*i +: 32];
            assign w_nempty[i] = (r_wp != r_rp);
            assign w_elig[i]   = io_bus.req_valid[i] & (r_cnt < c_DEPTH) & ~rst;
            assign w_pop[i]    = w_nempty[i] & io_bus.rsp_ready[i];
            assign w_wr[i]     = w_tag_v & (w_tag_id == IDW'(i));

            // Credit covers in-flight plus buffered, so the FIFO can never overflow
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_wp  <= '0;
                    r_rp  <= '0;
                end else begin
                    case ({w_gnt_vec[i], w_pop[i]})
                        2'b10:   r_cnt <= r_cnt + 1'b1;
                        2'b01:   r_cnt <= r_cnt - 1'b1;
                        default: r_cnt <= r_cnt;
                    endcase
                    if (w_wr[i]) begin
                        r_wp <= r_wp + 1'b1;
                    end
                    if (w_pop[i]) begin
                        r_rp <= r_rp + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_wr[i]) begin
                    r_mem[r_wp[AW-1:0]] <= io_bus.eng_y;
                end
            end

            assign io_bus.rsp_y[32*i +: 32] = r_mem[r_rp[AW-1:0]];
        end
    endgenerate

    assign io_bus.req_ready = w_gnt_vec;
    assign io_bus.rsp_valid = w_nempty;
    assign io_bus.eng_valid = r_eng_valid;
    assign io_bus.eng_x     = r_eng_x;
    assign io_bus.busy      = r_eng_valid | (|r_tag_v) | (|w_nempty);

`ifdef INV_SQRT_ARB_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_eng_valid) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
            if ((|io_bus.req_valid) && !w_gnt_any) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_issue = r_perf_issue;
    assign o_perf_stall = r_perf_stall;
`endif

endmodule
`default_nettype wire
